// File: rtl/load_size_seq_pkg.sv
// Shared CPU definitions for the load/store size paths: size codes and sequencer states.
package load_size_seq_pkg;

    typedef logic [1:0] size_t;

    // Size codes shared with the store-size merge logic.
    localparam size_t SIZE_NONE = 2'b00;
    localparam size_t SIZE_WORD = 2'b01;
    localparam size_t SIZE_HALF = 2'b10;
    localparam size_t SIZE_BYTE = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/load_extract.sv
// Combinational size extraction of a loaded word; sub-word lanes always come from the low bits.
module load_extract
    import load_size_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] word,
    output logic [31:0] result
);

    always_comb begin
        result = word;
        case (size)
            SIZE_HALF: result = {{16{sign_ext & word[15]}}, word[15:0]};
            SIZE_BYTE: result = {{24{sign_ext & word[7]}}, word[7:0]};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/load_size_seq.sv
// Load sequencer: issues a memory read, waits out MEM_LAT, and registers the
// size-extracted result plus the raw word for the write-back and MDR paths.
module load_size_seq
    import load_size_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  LSCtrl,
    input  logic        LSSigned,
    input  logic        abort,
    input  logic [31:0] Mem_data,
    output logic        MemRead,
    output logic        busy,
    output logic        done,
    output logic [31:0] Data_out,
    output logic [31:0] Data_raw
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    size_t            size_q, size_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      dout_q, raw_q;
    logic [31:0]      extracted;
    logic             capture;

    load_extract u_extract (
        .size     (size_q),
        .sign_ext (sgn_q),
        .word     (Mem_data),
        .result   (extracted)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (LSCtrl != SIZE_NONE)) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                    size_d  = LSCtrl;
                    sgn_d   = LSSigned;
                end
            end
            ST_WAIT: begin
                // abort wins over a capture landing on the same edge
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            size_q  <= SIZE_NONE;
            sgn_q   <= 1'b0;
            dout_q  <= '0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            if (capture) begin
                dout_q <= extracted;
                raw_q  <= Mem_data;
            end
        end
    end

    assign MemRead  = (state_q == ST_WAIT);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign Data_out = dout_q;
    assign Data_raw = raw_q;

endmodule

// File: tb/tb_load_size_seq.sv
// Scoreboard bench for load_size_seq, exercising MEM_LAT = 1, 2 and 4 instances in turn.
module tb_load_size_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  LSCtrl;
    logic        LSSigned;
    logic        abort;
    logic [31:0] mem_data;

    int sel = 0;
    int lat = 1;
    int lats [3] = '{1, 2, 4};

    logic        memread_v [3];
    logic        busy_v    [3];
    logic        done_v    [3];
    logic [31:0] dout_v    [3];
    logic [31:0] raw_v     [3];

    always #5 clk = ~clk;

    load_size_seq #(.MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(start && (sel == 0)), .LSCtrl(LSCtrl),
        .LSSigned(LSSigned), .abort(abort), .Mem_data(mem_data), .MemRead(memread_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .Data_out(dout_v[0]), .Data_raw(raw_v[0])
    );

    load_size_seq #(.MEM_LAT(2)) u_dut_l2 (
        .clk(clk), .reset_n(reset_n), .start(start && (sel == 1)), .LSCtrl(LSCtrl),
        .LSSigned(LSSigned), .abort(abort), .Mem_data(mem_data), .MemRead(memread_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .Data_out(dout_v[1]), .Data_raw(raw_v[1])
    );

    load_size_seq #(.MEM_LAT(4)) u_dut_l4 (
        .clk(clk), .reset_n(reset_n), .start(start && (sel == 2)), .LSCtrl(LSCtrl),
        .LSSigned(LSSigned), .abort(abort), .Mem_data(mem_data), .MemRead(memread_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .Data_out(dout_v[2]), .Data_raw(raw_v[2])
    );

    typedef struct {
        logic [31:0] dout;
        logic [31:0] raw;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];
    int   cyc      = 0;
    int   mr_cnt   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (MEM_LAT=%0d cycle=%0d)", tag, obs, exp, lat, cyc);
    endtask

    function automatic logic [31:0] model(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] w);
        logic signed [15:0] h;
        logic signed [7:0]  b;
        h = w[15:0];
        b = w[7:0];
        case (sz)
            2'b10:   return sg ? 32'(h) : {16'h0, w[15:0]};
            2'b11:   return sg ? 32'(b) : {24'h0, w[7:0]};
            default: return w;
        endcase
    endfunction

    // Scoreboard: every done pops one expectation, including the cycle it must land on.
    always @(negedge clk) begin
        exp_t e;
        if (memread_v[sel]) mr_cnt++;
        if (done_v[sel]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done_v[sel]), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", dout_v[sel], e.dout);
                check("data_raw", raw_v[sel], e.raw);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sz, input logic sg, input logic [31:0] w,
                         input logic [31:0] exp_dout, input logic [31:0] exp_raw);
        exp_t e;
        LSCtrl   = sz;
        LSSigned = sg;
        mem_data = w;
        start    = 1'b1;
        e.dout   = exp_dout;
        e.raw    = exp_raw;
        e.cyc    = cyc + 1 + lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy_v[sel]) return;
        end
        check("idle_timeout", 32'(busy_v[sel]), 32'd0);
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] w,
                        input logic [31:0] exp_dout);
        step();
        issue(sz, sg, w, exp_dout, w);
        step();
        start = 1'b0;
        wait_idle(20);
    endtask

    task automatic run_scenarios(input int k);
        logic [31:0] w;
        logic [1:0]  sz;
        logic        sg;
        sel = k;
        lat = lats[k];

        step();
        mr_cnt = 0;
        load(2'b11, 1'b0, 32'hDEADBEEF, 32'h000000EF);
        check("memread_cycles", mr_cnt, lat);
        load(2'b11, 1'b1, 32'hDEADBEEF, 32'hFFFFFFEF);
        load(2'b10, 1'b1, 32'h12348001, 32'hFFFF8001);
        load(2'b10, 1'b0, 32'h12348001, 32'h00008001);
        load(2'b01, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);

        // start with the no-op size must be ignored
        step();
        LSCtrl = 2'b00;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("noop_busy", 32'(busy_v[sel]), 32'd0);
            check("noop_memread", 32'(memread_v[sel]), 32'd0);
        end

        // re-request and data change mid-load; start held through DONE as well
        step();
        issue(2'b10, 1'b1, 32'h00008001, 32'hFFFF8001, 32'h12348001);
        step();
        LSCtrl   = 2'b11;
        LSSigned = 1'b0;
        mem_data = 32'h12348001;
        repeat (lat + 1) step();
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy_v[sel]), 32'd0);

        // back-to-back loads every MEM_LAT+2 cycles
        step();
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            w  = $urandom;
            sz = 2'($urandom_range(1, 3));
            sg = 1'($urandom_range(0, 1));
            issue(sz, sg, w, model(sz, sg, w), w);
            step();
            start = 1'b0;
            repeat (lat) step();
        end
        wait_idle(20);

        // abort in the first WAIT cycle
        load(2'b01, 1'b0, 32'h11111111, 32'h11111111);
        step();
        mem_data = 32'h22222222;
        LSCtrl   = 2'b11;
        LSSigned = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_memread", 32'(memread_v[sel]), 32'd0);
        check("abort_busy", 32'(busy_v[sel]), 32'd0);
        check("abort_dout", dout_v[sel], 32'h11111111);
        check("abort_raw", raw_v[sel], 32'h11111111);
        repeat (lat + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_v[sel]), 32'd0);
        end

        // asynchronous reset between edges while in WAIT
        step();
        mem_data = 32'hDEADBEEF;
        LSCtrl   = 2'b11;
        start    = 1'b1;
        step();
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_dout", dout_v[sel], 32'd0);
        check("rst_mid_raw", raw_v[sel], 32'd0);
        check("rst_mid_memread", 32'(memread_v[sel]), 32'd0);
        check("rst_mid_busy", 32'(busy_v[sel]), 32'd0);
        check("rst_mid_done", 32'(done_v[sel]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        load(2'b11, 1'b0, 32'hDEADBEEF, 32'h000000EF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        LSCtrl   = 2'b00;
        LSSigned = 1'b0;
        abort    = 1'b0;
        mem_data = 32'h0;
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            check("rst_dout", dout_v[k], 32'd0);
            check("rst_raw", raw_v[k], 32'd0);
            check("rst_memread", 32'(memread_v[k]), 32'd0);
            check("rst_busy", 32'(busy_v[k]), 32'd0);
            check("rst_done", 32'(done_v[k]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 3; k++) run_scenarios(k);

        repeat (3) step();
        check("pending_expectations", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
